// File: rtl/dcache_wb_if.sv
// Bundle of processor-side and memory-side signals for the write-back data cache.
// The cache connects through the slave modport, and the processor/memory environment through master.
interface dcache_wb_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache: 8 lines of 4 words each.
// Hits complete combinationally; a miss evicts a dirty victim first, then refills the line.
module dcache_wb (
  input  logic        clk,
  input  logic        rst_n,
  dcache_wb_if.slave  bus
);
  typedef enum logic [1:0] {S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [7:0]     r_valid;
  logic [7:0]     r_dirty;
  logic [24:0]    r_tag  [8];
  logic [127:0]   r_data [8];

  logic [2:0]     w_index;
  logic [1:0]     w_offset;
  logic [24:0]    w_tag;
  logic           w_req;
  logic           w_hit;
  logic           w_wr_hit;
  logic           w_fill;
  logic [127:0]   w_line;
  logic [127:0]   w_merged;

  assign w_index  = bus.proc_addr[4:2];
  assign w_offset = bus.proc_addr[1:0];
  assign w_tag    = bus.proc_addr[29:5];
  assign w_req    = bus.proc_read | bus.proc_write;
  assign w_line   = r_data[w_index];
  assign w_hit    = r_valid[w_index] & (r_tag[w_index] == w_tag);
  // A simultaneous read and write is serviced as a write.
  assign w_wr_hit = (r_state == S_COMPARE) & bus.proc_write & w_hit;
  assign w_fill   = (r_state == S_ALLOCATE) & bus.mem_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign w_merged[gi*32 +: 32] = (w_offset == 2'(gi)) ? bus.proc_wdata : w_line[gi*32 +: 32];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COMPARE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_COMPARE: begin
        if (w_req && !w_hit) begin
          w_state_next = (r_valid[w_index] && r_dirty[w_index]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: if (bus.mem_ready) w_state_next = S_ALLOCATE;
      S_ALLOCATE:  if (bus.mem_ready) w_state_next = S_COMPARE;
      default:     w_state_next = S_COMPARE;
    endcase
  end

  always_comb begin
    bus.proc_stall = 1'b1;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = bus.proc_addr[29:2];
    bus.mem_wdata  = w_line;
    bus.proc_rdata = w_line[{w_offset, 5'd0} +: 32];
    unique case (r_state)
      S_COMPARE:   bus.proc_stall = w_req & ~w_hit;
      S_WRITEBACK: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {r_tag[w_index], w_index};
      end
      S_ALLOCATE:  bus.mem_read = 1'b1;
      default:     bus.proc_stall = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= 1'b0;
    end else if (w_wr_hit) begin
      r_dirty[w_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_index] <= bus.mem_rdata;
      r_tag[w_index]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_index] <= w_merged;
    end
  end
endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: fills, hits, dirty eviction, clean conflict and reset abort.
module tb_dcache_wb;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dcache_wb_if bus ();

  dcache_wb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] BLK_D = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
  localparam logic [127:0] BLK_E = {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0};
  localparam logic [127:0] BLK_F = {32'hF3F3F3F3, 32'hF2F2F2F2, 32'hF1F1F1F1, 32'hF0F0F0F0};
  localparam logic [127:0] BLK_G = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [29:0] addr, input logic [31:0] wd);
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = addr;
    bus.proc_wdata = wd;
    #1;
  endtask

  task automatic idle();
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    #1;
  endtask

  task automatic mem_pulse(input logic [127:0] blk);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = blk;
    #1;
    chk("stall_during_ready", 128'(bus.proc_stall), 128'd1);
    step();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_stall", 128'(bus.proc_stall), 128'd0);
    chk("rst_mem_read", 128'(bus.mem_read), 128'd0);
    chk("rst_mem_write", 128'(bus.mem_write), 128'd0);
    rst_n = 1'b1;
    step();
    chk("idle_stall", 128'(bus.proc_stall), 128'd0);

    // Cold miss on 0x5: allocate block 1 and return word 1.
    req(1'b1, 1'b0, 30'h5, 32'h0);
    chk("cold_miss_stall", 128'(bus.proc_stall), 128'd1);
    step();
    chk("alloc1_mem_read", 128'(bus.mem_read), 128'd1);
    chk("alloc1_mem_write", 128'(bus.mem_write), 128'd0);
    chk("alloc1_addr", 128'(bus.mem_addr), 128'h1);
    step();
    chk("alloc1_hold", 128'(bus.mem_read), 128'd1);
    mem_pulse(BLK_D);
    chk("fill1_stall", 128'(bus.proc_stall), 128'd0);
    chk("fill1_rdata", 128'(bus.proc_rdata), 128'hD1D1D1D1);
    chk("fill1_mem_read", 128'(bus.mem_read), 128'd0);
    step();
    idle();

    // Neighbouring word hits with no memory traffic.
    req(1'b1, 1'b0, 30'h6, 32'h0);
    chk("hit6_stall", 128'(bus.proc_stall), 128'd0);
    chk("hit6_rdata", 128'(bus.proc_rdata), 128'hD2D2D2D2);
    chk("hit6_mem", 128'({bus.mem_read, bus.mem_write}), 128'd0);
    step();

    req(1'b0, 1'b1, 30'h4, 32'hDEADBEEF);
    chk("wr4_stall", 128'(bus.proc_stall), 128'd0);
    step();
    req(1'b1, 1'b0, 30'h4, 32'h0);
    chk("rd4_rdata", 128'(bus.proc_rdata), 128'hDEADBEEF);
    req(1'b1, 1'b0, 30'h7, 32'h0);
    chk("rd7_untouched", 128'(bus.proc_rdata), 128'hD3D3D3D3);
    step();
    idle();

    // Memory handshake outside a transfer must not move the FSM.
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    #1;
    chk("stray_ready_mem", 128'({bus.mem_read, bus.mem_write}), 128'd0);
    chk("stray_ready_stall", 128'(bus.proc_stall), 128'd0);

    // Dirty conflict on index 1: evict then refill.
    req(1'b1, 1'b0, 30'h24, 32'h0);
    chk("dirty_miss_stall", 128'(bus.proc_stall), 128'd1);
    step();
    chk("wb_mem_write", 128'(bus.mem_write), 128'd1);
    chk("wb_mem_read", 128'(bus.mem_read), 128'd0);
    chk("wb_addr", 128'(bus.mem_addr), 128'h1);
    chk("wb_wdata", bus.mem_wdata, {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hDEADBEEF});
    mem_pulse(128'h0);
    chk("wb_then_read", 128'(bus.mem_read), 128'd1);
    chk("wb_then_nowrite", 128'(bus.mem_write), 128'd0);
    chk("alloc9_addr", 128'(bus.mem_addr), 128'h9);
    mem_pulse(BLK_E);
    chk("fill9_stall", 128'(bus.proc_stall), 128'd0);
    chk("fill9_rdata", 128'(bus.proc_rdata), 128'hE0E0E0E0);
    step();
    idle();

    // Clean conflict on index 1: straight to allocate.
    req(1'b1, 1'b0, 30'h4, 32'h0);
    chk("clean_miss_stall", 128'(bus.proc_stall), 128'd1);
    step();
    chk("clean_mem_write", 128'(bus.mem_write), 128'd0);
    chk("clean_mem_read", 128'(bus.mem_read), 128'd1);
    chk("clean_addr", 128'(bus.mem_addr), 128'h1);
    mem_pulse(BLK_F);
    chk("clean_fill_rdata", 128'(bus.proc_rdata), 128'hF0F0F0F0);
    chk("clean_fill_stall", 128'(bus.proc_stall), 128'd0);
    step();

    // Read and write together is a write.
    req(1'b1, 1'b1, 30'h5, 32'h12345678);
    chk("rw_stall", 128'(bus.proc_stall), 128'd0);
    step();
    req(1'b1, 1'b0, 30'h5, 32'h0);
    chk("rw_readback", 128'(bus.proc_rdata), 128'h12345678);
    step();
    idle();

    // Reset mid-allocate aborts the fill.
    req(1'b1, 1'b0, 30'h0E, 32'h0);
    step();
    chk("alloc3_mem_read", 128'(bus.mem_read), 128'd1);
    chk("alloc3_addr", 128'(bus.mem_addr), 128'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_read", 128'(bus.mem_read), 128'd0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = BLK_G;
    step();
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_miss_e", 128'(bus.proc_stall), 128'd1);
    req(1'b1, 1'b0, 30'h5, 32'h0);
    chk("post_rst_miss_5", 128'(bus.proc_stall), 128'd1);
    idle();
    chk("post_rst_idle", 128'(bus.proc_stall), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dcache_wb.md
DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 proc_read  input  1  processor read request, word-addressed, held until proc_stall low.
REQ-004 proc_write  input  1  processor write request, held until proc_stall low.
REQ-005 proc_addr  input  30  word address: [1:0] word offset, [4:2] index, [29:5] tag.
REQ-006 proc_wdata  input  32  write data.
REQ-007 proc_stall  output  1  high while request cannot complete this cycle.
REQ-008 proc_rdata  output  32  read data, valid when proc_read high and proc_stall low.
REQ-009 mem_read  output  1  block read request to memory.
REQ-010 mem_write  output  1  block write request to memory.
REQ-011 mem_addr  output  28  block address {tag,index}.
REQ-012 mem_wdata  output  128  victim block, word 0 in [31:0].
REQ-013 mem_ready  input  1  one-cycle pulse completing current memory request.
REQ-014 mem_rdata  input  128  fill block, valid while mem_ready high.

Function
REQ-015 Organisation SHALL be direct-mapped, 8 lines x 4 words, write-back, write-allocate; per line: valid, dirty, 25-bit tag, 128-bit data.
REQ-016 Hit SHALL be valid[index] & (tag[index]==proc_addr[29:5]).
REQ-017 States SHALL be COMPARE, WRITEBACK, ALLOCATE; reset state COMPARE.
REQ-018 COMPARE, no request: proc_stall=0, mem_read=mem_write=0, no state change.
REQ-019 COMPARE, read hit: proc_stall=0 same cycle; proc_rdata = data word selected by proc_addr[1:0], combinational; zero added latency.
REQ-020 COMPARE, write hit: proc_stall=0; at clock edge selected word <- proc_wdata, dirty[index] <- 1; other three words unchanged.
REQ-021 COMPARE, miss with line invalid or clean: proc_stall=1; next state ALLOCATE.
REQ-022 COMPARE, miss with line valid and dirty: proc_stall=1; next state WRITEBACK.
REQ-023 WRITEBACK: mem_write=1, mem_addr={stored tag,index}, mem_wdata=stored block, held stable; on mem_ready next state ALLOCATE.
REQ-024 ALLOCATE: mem_read=1, mem_addr=proc_addr[29:2], held stable; on mem_ready line data <- mem_rdata, tag <- proc_addr[29:5], valid <- 1, dirty <- 0; next state COMPARE.
REQ-025 After ALLOCATE, the request SHALL complete as a hit in COMPARE the following cycle (miss cost = memory cycles + 1).
REQ-026 proc_stall SHALL be 1 in WRITEBACK and ALLOCATE, including the mem_ready cycle.
REQ-027 mem_read and mem_write SHALL be decoded from state only (Moore), never both high.
REQ-028 proc_read and proc_write both high SHALL be treated as write.
REQ-029 mem_ready outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-030 Processor request/address change while stalled is illegal; behaviour unspecified.

Reset
REQ-031 rst_n low SHALL immediately force state COMPARE, all valid and dirty bits 0, mem_read=mem_write=0.
REQ-032 Reset mid-WRITEBACK/ALLOCATE SHALL abort the transfer; tag/data arrays need not reset.
REQ-033 After reset, proc_stall SHALL be 0 with no request, 1 for any request (all miss).

Verification
REQ-034 After reset, read addr 0x00000005 -> stall, mem_read with mem_addr 0x0000001; mem_ready with mem_rdata {D3,D2,D1,D0} -> next cycle stall=0, proc_rdata=D1.
REQ-035 Then read 0x00000006 -> stall=0 same cycle, proc_rdata=D2, no memory traffic.
REQ-036 Write 0x00000004 data 0xDEADBEEF (hit) -> no stall; read 0x00000004 returns 0xDEADBEEF; dirty[1]=1.
REQ-037 Read 0x00000024 (same index 1, tag 1) -> mem_write, mem_addr 0x0000001, mem_wdata {D3,D2,D1,0xDEADBEEF}; after mem_ready, mem_read mem_addr 0x0000009; after fill, data returned.
REQ-038 Clean conflict miss (index 1, no writes) -> mem_read only, mem_write never asserted.
REQ-039 Assert rst_n low during ALLOCATE -> mem_read drops asynchronously; subsequent read of prior address misses again.
